// File: rtl/adder_pkg.sv
// Shared definitions for the 4-bit adder/subtractor datapath.
//   ADD_W     : operand width of the adder chain
//   pg_word_t : propagate/generate word handed from the operand stage
//               to the carry-generation unit and the sum stage
//   occ_t     : occupancy of the two-entry operand skid buffer
//   pg_form   : forms {p, g, cin, sa, sb} from raw operands
package adder_pkg;

  localparam int ADD_W = 4;

  typedef struct packed {
    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] g;
    logic             cin;
    logic             sa;
    logic             sb;
  } pg_word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // Subtraction is A + ~B + 1: B is inverted here, the +1 rides in as cin.
  function automatic pg_word_t pg_form(input logic [ADD_W-1:0] a,
                                       input logic [ADD_W-1:0] b,
                                       input logic             sub);
    logic [ADD_W-1:0] b_eff;
    pg_word_t         w;
    b_eff = sub ? ~b : b;
    w.p   = a ^ b_eff;
    w.g   = a & b_eff;
    w.cin = sub;
    w.sa  = a[ADD_W-1];
    w.sb  = b_eff[ADD_W-1];
    return w;
  endfunction

endpackage

// File: rtl/pg_skid_buf.sv
// Two-entry skid buffer carrying pg_word_t between the operand stage and the CGU.
// The main entry drives the output; the skid entry catches the word accepted
// while the main entry is stalled, so in_ready can be a plain flop.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready registered)
//   in_word              payload accepted when in_valid & in_ready
//   out_valid / out_ready downstream handshake
//   out_word             main entry, stable while out_valid & ~out_ready
module pg_skid_buf
  import adder_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  pg_word_t in_word,
  output logic     out_valid,
  input  logic     out_ready,
  output pg_word_t out_word
);

  occ_t     state, state_nxt;
  logic     ready_p1;
  pg_word_t main_p1, skid_p1;
  logic     accept, xfer;
  logic     load_main_in, load_main_skid, load_skid;

  assign accept = in_valid & ready_p1;
  assign xfer   = (state != OCC_EMPTY) & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (accept) begin
          state_nxt    = OCC_ONE;
          load_main_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && xfer) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = OCC_FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only the drain path is possible.
        if (xfer) begin
          state_nxt      = OCC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  // ---- stage p1: occupancy and registered ready ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OCC_EMPTY;
      ready_p1 <= 1'b1;
    end else begin
      state    <= state_nxt;
      ready_p1 <= (state_nxt != OCC_FULL);
    end
  end

  // Payload is cleared on reset so the outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_in)        main_p1 <= in_word;
      else if (load_main_skid) main_p1 <= skid_p1;
      if (load_skid)           skid_p1 <= in_word;
    end
  end

  assign in_ready  = ready_p1;
  assign out_valid = (state != OCC_EMPTY);
  assign out_word  = main_p1;

endmodule

// File: rtl/pg_operand_stage.sv
// Registered propagate/generate front end of the 4-bit adder/subtractor.
// Forms p = A ^ B', g = A & B', cin = sub (B' = ~B when subtracting) and
// hands the word to the CGU through a two-entry skid buffer.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready registered)
//   in_a, in_b, in_sub    operands and add(0)/sub(1) select
//   out_valid / out_ready result handshake toward the CGU
//   out_p, out_g, out_cin propagate, generate, carry-in
//   out_sa, out_sb        A and B' sign bits for overflow detection
//   op_count              accepted operations since reset, saturating
module pg_operand_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic             out_cin,
  output logic             out_sa,
  output logic             out_sb,
  output logic [CNT_W-1:0] op_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  pg_word_t word_p0, word_p1;
  logic     accept;

  // ---- stage p0: combinational PG formation on the input side ----
  assign word_p0 = pg_form(in_a, in_b, in_sub);
  assign accept  = in_valid & in_ready;

  // ---- stage p1: registered in the skid buffer ----
  pg_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (word_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (word_p1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)      op_count <= '0;
    else if (accept) op_count <= sat_inc(op_count);
  end

  assign out_p   = word_p1.p;
  assign out_g   = word_p1.g;
  assign out_cin = word_p1.cin;
  assign out_sa  = word_p1.sa;
  assign out_sb  = word_p1.sb;

endmodule

// File: tb/tb_pg_operand_stage.sv
module tb_pg_operand_stage;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic       out_cin, out_sa, out_sb;
  logic [3:0] in_a, in_b, out_p, out_g;
  logic [7:0] op_count;

  logic       s_in_valid, s_in_ready, s_in_sub, s_out_valid, s_out_ready;
  logic       s_cin, s_sa, s_sb;
  logic [3:0] s_in_a, s_in_b, s_p, s_g;
  logic [2:0] s_cnt;

  pg_operand_stage #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_g(out_g), .out_cin(out_cin),
    .out_sa(out_sa), .out_sb(out_sb), .op_count(op_count)
  );

  pg_operand_stage #(.WIDTH(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_sub(s_in_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_p(s_p), .out_g(s_g), .out_cin(s_cin),
    .out_sa(s_sa), .out_sb(s_sb), .op_count(s_cnt)
  );

  int          n_vec = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          stalls = 0;
  int          exp_cnt = 0;
  logic [10:0] exp_q[$];

  // Reference: B' is the one's complement (15 - B) when subtracting.
  function automatic logic [10:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic s);
    int         be;
    logic [3:0] bv;
    be = s ? (15 - int'(b)) : int'(b);
    bv = be[3:0];
    return {a ^ bv, a & bv, s, a[3], bv[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller enters just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic s);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, s));
        if (exp_cnt < 255) exp_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  logic [10:0] prev_word;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [10:0] cur;
    cur = {out_p, out_g, out_cin, out_sa, out_sb};
    if (rst_n) begin
      if (prev_stall) chk("hold_stable", 32'(cur), 32'(prev_word));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 32'(cur), 32'h7ff);
        else                   chk("out_word", 32'(cur), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = 4'ha; s_in_b = 4'h6; s_in_sub = 1'b1; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_pg", 32'({out_p, out_g}), 0);
    chk("rst_flags", 32'({out_cin, out_sa, out_sb}), 0);
    chk("rst_count", 32'(op_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed add
    send(4'b0011, 4'b0101, 1'b0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_p", 32'(out_p), 32'b0110);
    chk("add_g", 32'(out_g), 32'b0001);
    chk("add_flags", 32'({out_cin, out_sa, out_sb}), 32'b000);
    chk("add_count", 32'(op_count), 1);
    @(posedge clk); #1;

    // Directed sub
    send(4'b0101, 4'b0011, 1'b1);
    @(negedge clk);
    chk("sub_p", 32'(out_p), 32'b1001);
    chk("sub_g", 32'(out_g), 32'b0100);
    chk("sub_flags", 32'({out_cin, out_sa, out_sb}), 32'b101);
    @(posedge clk); #1;

    // Back-pressure: two words fill the buffer, the third waits upstream
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (4) @(posedge clk); #1;
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_count", 32'(op_count), 4);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", 32'(exp_q.size()), 0);
    chk("bp_in_ready_high", 32'(in_ready), 1);

    // Streaming
    stalls = 0;
    o0 = n_out;
    for (int i = 0; i < 20; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk); #1;
    chk("stream_stalls", 32'(stalls), 0);
    chk("stream_outs", 32'(n_out - o0), 20);
    chk("stream_count", 32'(op_count), 32'(exp_cnt));

    // Reset while FULL: buffered words must never appear
    out_ready = 1'b0;
    send(4'h7, 4'h2, 1'b0);
    send(4'h9, 4'h4, 1'b1);
    @(negedge clk);
    chk("full_before_rst", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_count", 32'(op_count), 0);
    o0 = n_out;
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("no_ghost_outs", 32'(n_out - o0), 0);
    send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk); #1;
    chk("post_rst_drained", 32'(exp_q.size()), 0);
    chk("post_rst_count", 32'(op_count), 1);

    // Saturation on the 3-bit counter build
    s_in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("sat_count", 32'(s_cnt), 32'((i > 7) ? 7 : i));
    end
    s_in_valid = 1'b0;
    chk("sat_word", 32'({s_p, s_g, s_cin, s_sa, s_sb}), 32'(model(s_in_a, s_in_b, s_in_sub)));
    chk("sat_ready", 32'({s_in_ready, s_out_valid}), 32'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
